qrs_decision: RTL and testbench

Adaptive-threshold QRS decision stage of the Pan-Tompkins pipeline. Consumes the moving-window-integrated signal at 200 samples/s and detects local peaks. Classifies each peak as signal or noise against running thresholds and performs searchback when no beat arrives within `rrmiss`. Drives `rru`/`rr_interval` into `rr_update` directly downstream and takes `rrmiss` back from it.

---
 rtl/pt_pkg.sv | 14 +
 rtl/peak_detector.sv | 35 +++
 rtl/qrs_decision.sv | 216 +++++++++++++++++++++
 tb/tb_qrs_decision.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared constants and state encoding for the Pan-Tompkins decision path.
// Used by qrs_decision and by rr_update downstream.
package pt_pkg;

  localparam int PT1000MS = 200;  // samples per second at 200 Hz
  localparam int REFRACT  = 40;   // 200 ms refractory window
  localparam int LEARN    = 400;  // 2 s threshold learning phase

  typedef enum logic {
    ST_LEARN  = 1'b0,
    ST_DETECT = 1'b1
  } state_e;

endpackage

// File: rtl/peak_detector.sv
// Local-maximum detector on the integrated signal.
// Ports:
//   clk, rstn : clock, async active-low reset
//   adv_i     : advance the delay line (one accepted sample)
//   x_i       : current sample x[n]
//   peak_o    : x[n-1] is a positive local max (x1 > x2, x1 >= x, x1 > 0)
//   p_o       : peak value, x[n-1]
module peak_detector #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         adv_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic                         peak_o,
  output logic signed [DATA_WIDTH-1:0] p_o
);

  logic signed [DATA_WIDTH-1:0] x1_q, x2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (adv_i) begin
      x2_q <= x1_q;
      x1_q <= x_i;
    end
  end

  // Non-positive maxima are never candidates, so filter them here.
  assign peak_o = (x1_q > x2_q) && (x1_q >= x_i) && (x1_q > '0);
  assign p_o    = x1_q;

endmodule

// File: rtl/qrs_decision.sv
// Adaptive-threshold QRS decision with searchback.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   en            : global enable; low freezes state and forces pulses to 0
//   sample_valid  : one-cycle strobe for a new sample on x
//   x             : signed integrated sample
//   rrmiss        : signed searchback limit from rr_update
//   rru           : pulse, rr_interval updated
//   rr_interval   : samples between the last two accepted beats
//   qrs           : pulse per accepted beat
//   searchback    : pulse, beat accepted through searchback
//   thr1          : current primary threshold
module qrs_decision #(
  parameter int DATA_WIDTH = 16,
  parameter int PT1000MS   = pt_pkg::PT1000MS,
  parameter int REFRACT    = pt_pkg::REFRACT,
  parameter int LEARN      = pt_pkg::LEARN
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] rrmiss,
  output logic                         rru,
  output logic signed [DATA_WIDTH-1:0] rr_interval,
  output logic                         qrs,
  output logic                         searchback,
  output logic signed [DATA_WIDTH-1:0] thr1
);
  import pt_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(LEARN + 1);

  localparam logic signed [W:0]   HI_X  = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   LO_X  = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ONE   = W'(1);
  localparam logic signed [W-1:0] RFR   = W'(REFRACT);
  localparam logic signed [W-1:0] RR0   = W'(PT1000MS);
  localparam logic [CW-1:0]       LLAST = CW'(LEARN - 1);

  // Clip a W+1 bit intermediate back into the W-bit signed range.
  function automatic logic signed [W-1:0] clip(input logic signed [W:0] v);
    logic signed [W-1:0] r;
    if (v > HI_X)      r = SMAX;
    else if (v < LO_X) r = ~SMAX;
    else               r = v[W-1:0];
    return r;
  endfunction

  // c + ((t - c) >>> sh), all in W+1 bits. Kept as separate signed
  // statements so the shift stays arithmetic.
  function automatic logic signed [W-1:0] step_to(input logic signed [W-1:0] c,
                                                  input logic signed [W-1:0] t,
                                                  input int unsigned sh);
    logic signed [W:0] ce, te, df, sdf, sum;
    ce  = {c[W-1], c};
    te  = {t[W-1], t};
    df  = te - ce;
    sdf = df >>> sh;
    sum = ce + sdf;
    return clip(sum);
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       lcnt_q, lcnt_d;
  logic signed [W-1:0] lmax_q, lmax_d;
  logic signed [W-1:0] spki_q, spki_d, npki_q, npki_d;
  logic signed [W-1:0] thr1_q, thr1_d;
  logic signed [W-1:0] d_q, d_d;
  logic signed [W-1:0] sb_peak_q, sb_peak_d, sb_d_q, sb_d_d;
  logic                sb_valid_q, sb_valid_d;
  logic                first_q, first_d;
  logic signed [W-1:0] rr_q, rr_d;
  logic                rru_q, rru_d, qrs_q, qrs_d, sbp_q, sbp_d;

  logic                adv;
  logic                pk_peak;
  logic signed [W-1:0] pk_p;
  logic signed [W-1:0] d_inc, thr2;
  logic signed [W:0]   d_rem;
  logic                pk_ok, sig_pk, noise_pk, sb_hit;

  assign adv = en && sample_valid;

  peak_detector #(.DATA_WIDTH(W)) u_pk (
    .clk    (clk),
    .rstn   (rstn),
    .adv_i  (adv),
    .x_i    (x),
    .peak_o (pk_peak),
    .p_o    (pk_p)
  );

  assign d_inc    = (d_q == SMAX) ? d_q : d_q + ONE;
  assign thr2     = thr1_q >>> 1;
  assign d_rem    = {d_inc[W-1], d_inc} - {sb_d_q[W-1], sb_d_q};
  assign pk_ok    = (state_q == ST_DETECT) && pk_peak && (d_q >= RFR);
  assign sig_pk   = pk_ok && (pk_p >= thr1_q);
  assign noise_pk = pk_ok && !(pk_p >= thr1_q);
  // Searchback looks at the candidate held before this sample; a signal
  // peak on the same sample takes precedence.
  assign sb_hit   = (state_q == ST_DETECT) && !sig_pk && (d_inc >= rrmiss) &&
                    sb_valid_q && (sb_peak_q >= thr2) && !first_q;

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    lmax_d     = lmax_q;
    spki_d     = spki_q;
    npki_d     = npki_q;
    thr1_d     = thr1_q;
    d_d        = d_q;
    sb_peak_d  = sb_peak_q;
    sb_d_d     = sb_d_q;
    sb_valid_d = sb_valid_q;
    first_d    = first_q;
    rr_d       = rr_q;
    rru_d      = 1'b0;
    qrs_d      = 1'b0;
    sbp_d      = 1'b0;

    if (adv) begin
      d_d = d_inc;
      case (state_q)
        ST_LEARN: begin
          lmax_d = (x > lmax_q) ? x : lmax_q;
          lcnt_d = lcnt_q + 1'b1;
          if (lcnt_q == LLAST) begin
            state_d = ST_DETECT;
            spki_d  = lmax_d >>> 1;
            npki_d  = lmax_d >>> 3;
          end
        end
        default: begin
          if (sig_pk) begin
            spki_d     = step_to(spki_q, pk_p, 3);
            qrs_d      = 1'b1;
            sb_valid_d = 1'b0;
            d_d        = ONE;
            if (first_q) begin
              first_d = 1'b0;
            end else begin
              rr_d  = d_q;
              rru_d = 1'b1;
            end
          end else if (noise_pk) begin
            npki_d = step_to(npki_q, pk_p, 3);
            if (!sb_valid_q || (pk_p > sb_peak_q)) begin
              sb_peak_d  = pk_p;
              sb_d_d     = d_q;
              sb_valid_d = 1'b1;
            end
          end
          // A searchback accept consumes the candidate, even one just
          // refreshed by a noise peak on this sample.
          if (sb_hit) begin
            spki_d     = step_to(spki_q, sb_peak_q, 2);
            rr_d       = sb_d_q;
            rru_d      = 1'b1;
            qrs_d      = 1'b1;
            sbp_d      = 1'b1;
            d_d        = clip(d_rem);
            sb_valid_d = 1'b0;
          end
        end
      endcase
      thr1_d = step_to(npki_d, spki_d, 2);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_LEARN;
      lcnt_q     <= '0;
      lmax_q     <= '0;
      spki_q     <= '0;
      npki_q     <= '0;
      thr1_q     <= '0;
      d_q        <= '0;
      sb_peak_q  <= '0;
      sb_d_q     <= '0;
      sb_valid_q <= 1'b0;
      first_q    <= 1'b1;
      rr_q       <= RR0;
      rru_q      <= 1'b0;
      qrs_q      <= 1'b0;
      sbp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      lmax_q     <= lmax_d;
      spki_q     <= spki_d;
      npki_q     <= npki_d;
      thr1_q     <= thr1_d;
      d_q        <= d_d;
      sb_peak_q  <= sb_peak_d;
      sb_d_q     <= sb_d_d;
      sb_valid_q <= sb_valid_d;
      first_q    <= first_d;
      rr_q       <= rr_d;
      rru_q      <= rru_d;
      qrs_q      <= qrs_d;
      sbp_q      <= sbp_d;
    end
  end

  assign rru         = rru_q;
  assign qrs         = qrs_q;
  assign searchback  = sbp_q;
  assign rr_interval = rr_q;
  assign thr1        = thr1_q;

endmodule

// File: tb/tb_qrs_decision.sv
module tb_qrs_decision;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               en = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] x = '0;
  logic signed [15:0] rrmiss = 16'sd332;
  logic               rru, qrs, searchback;
  logic signed [15:0] rr_interval, thr1;

  int checks = 0;
  int errors = 0;
  int n_qrs = 0, n_rru = 0, n_sb = 0;
  logic c_rru, c_qrs, c_sb;
  logic signed [15:0] c_rr;

  qrs_decision dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .sample_valid (sample_valid),
    .x            (x),
    .rrmiss       (rrmiss),
    .rru          (rru),
    .rr_interval  (rr_interval),
    .qrs          (qrs),
    .searchback   (searchback),
    .thr1         (thr1)
  );

  always #5 clk = ~clk;

  // One sample: strobe across a rising edge, capture registered outputs after it.
  task automatic step(input logic signed [15:0] v);
    @(negedge clk);
    x = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    c_rru = rru; c_qrs = qrs; c_sb = searchback; c_rr = rr_interval;
    n_qrs += int'(qrs); n_rru += int'(rru); n_sb += int'(searchback);
  endtask

  task automatic zeros(input int n);
    repeat (n) step(16'sd0);
  endtask

  task automatic clr_cnt();
    n_qrs = 0; n_rru = 0; n_sb = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rru, qrs, searchback} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {rru, qrs, searchback});
    end
    checks++;
    if (rr_interval !== 16'sd200 || thr1 !== 16'sd0) begin
      errors++; $display("FAIL reset_regs rr=%0d thr1=%0d exp 200/0", rr_interval, thr1);
    end
    rstn = 1'b1;
  endtask

  task automatic test_learning();
    clr_cnt();
    zeros(9);
    step(16'sd800);
    zeros(389);           // 399 samples so far
    checks++;
    if (thr1 !== 16'sd0) begin
      errors++; $display("FAIL learn_399 thr1 got %0d exp 0", thr1);
    end
    step(16'sd0);         // 400th sample closes learning
    checks++;
    if (thr1 !== 16'sd175) begin
      errors++; $display("FAIL learn_thr1 got %0d exp 175", thr1);
    end
    checks++;
    if (dut.spki_q !== 16'sd400 || dut.npki_q !== 16'sd100) begin
      errors++; $display("FAIL learn_pk spki=%0d npki=%0d exp 400/100", dut.spki_q, dut.npki_q);
    end
    checks++;
    if (n_qrs + n_rru + n_sb != 0) begin
      errors++; $display("FAIL learn_quiet pulses=%0d exp 0", n_qrs + n_rru + n_sb);
    end
  endtask

  task automatic test_first_beat();
    step(16'sd800);
    step(16'sd0);
    checks++;
    if (c_qrs !== 1'b1 || c_rru !== 1'b0 || c_sb !== 1'b0) begin
      errors++; $display("FAIL first_beat qrs/rru/sb got %b%b%b exp 100", c_qrs, c_rru, c_sb);
    end
    checks++;
    if (dut.spki_q !== 16'sd450 || thr1 !== 16'sd187) begin
      errors++; $display("FAIL first_thr spki=%0d thr1=%0d exp 450/187", dut.spki_q, thr1);
    end
  endtask

  task automatic test_second_beat();
    clr_cnt();
    zeros(198);
    step(16'sd800);
    step(16'sd0);         // decision at d=200
    checks++;
    if (c_qrs !== 1'b1 || c_rru !== 1'b1 || c_rr !== 16'sd200) begin
      errors++; $display("FAIL second_beat qrs=%b rru=%b rr=%0d exp 1/1/200", c_qrs, c_rru, c_rr);
    end
    checks++;
    if (dut.spki_q !== 16'sd493 || thr1 !== 16'sd198 || n_qrs != 1) begin
      errors++; $display("FAIL second_thr spki=%0d thr1=%0d nqrs=%0d exp 493/198/1", dut.spki_q, thr1, n_qrs);
    end
  endtask

  task automatic test_refractory();
    clr_cnt();
    zeros(28);
    step(16'sd900);
    step(16'sd0);         // decision at d=30
    checks++;
    if (n_qrs != 0 || dut.spki_q !== 16'sd493 || thr1 !== 16'sd198) begin
      errors++; $display("FAIL refractory nqrs=%0d spki=%0d thr1=%0d exp 0/493/198", n_qrs, dut.spki_q, thr1);
    end
  endtask

  task automatic test_noise();
    clr_cnt();
    zeros(118);
    step(16'sd120);
    step(16'sd0);         // noise decision at d=150
    checks++;
    if (n_qrs != 0 || dut.npki_q !== 16'sd102 || thr1 !== 16'sd199) begin
      errors++; $display("FAIL noise nqrs=%0d npki=%0d thr1=%0d exp 0/102/199", n_qrs, dut.npki_q, thr1);
    end
  endtask

  task automatic test_searchback();
    clr_cnt();
    zeros(180);           // d_new reaches 331
    checks++;
    if (n_qrs != 0 || n_sb != 0) begin
      errors++; $display("FAIL sb_early qrs=%0d sb=%0d exp 0/0", n_qrs, n_sb);
    end
    step(16'sd0);         // d_new = 332 = rrmiss
    checks++;
    if (c_sb !== 1'b1 || c_rru !== 1'b1 || c_qrs !== 1'b1 || c_rr !== 16'sd150) begin
      errors++; $display("FAIL searchback sb=%b rru=%b qrs=%b rr=%0d exp 1/1/1/150", c_sb, c_rru, c_qrs, c_rr);
    end
    checks++;
    if (dut.d_q !== 16'sd182 || dut.spki_q !== 16'sd399 || thr1 !== 16'sd176) begin
      errors++; $display("FAIL sb_state d=%0d spki=%0d thr1=%0d exp 182/399/176", dut.d_q, dut.spki_q, thr1);
    end
  endtask

  task automatic test_back_to_back();
    step(16'sd150);
    step(16'sd0);         // noise candidate, sb_d = 183
    checks++;
    if (thr1 !== 16'sd180 || c_qrs !== 1'b0) begin
      errors++; $display("FAIL b2b_noise thr1=%0d qrs=%b exp 180/0", thr1, c_qrs);
    end
    rrmiss = 16'sd200;
    clr_cnt();
    zeros(14);
    step(16'sd800);
    checks++;
    if (n_sb != 0 || n_qrs != 0) begin
      errors++; $display("FAIL b2b_early sb=%0d qrs=%0d exp 0/0", n_sb, n_qrs);
    end
    step(16'sd0);         // signal peak at d=199, searchback also eligible
    checks++;
    if (c_qrs !== 1'b1 || c_sb !== 1'b0 || c_rru !== 1'b1 || c_rr !== 16'sd199) begin
      errors++; $display("FAIL b2b_win qrs=%b sb=%b rru=%b rr=%0d exp 1/0/1/199", c_qrs, c_sb, c_rru, c_rr);
    end
    checks++;
    if (thr1 !== 16'sd193 || dut.sb_valid_q !== 1'b0) begin
      errors++; $display("FAIL b2b_state thr1=%0d sbv=%b exp 193/0", thr1, dut.sb_valid_q);
    end
  endtask

  task automatic test_enable();
    zeros(5);
    checks++;
    if (dut.d_q !== 16'sd6) begin
      errors++; $display("FAIL en_pre d=%0d exp 6", dut.d_q);
    end
    en = 1'b0;
    clr_cnt();
    for (int i = 0; i < 50; i++) step((i % 2 == 0) ? 16'sd900 : 16'sd0);
    checks++;
    if (n_qrs + n_rru + n_sb != 0 || dut.d_q !== 16'sd6 || thr1 !== 16'sd193) begin
      errors++; $display("FAIL en_freeze pulses=%0d d=%0d thr1=%0d exp 0/6/193", n_qrs + n_rru + n_sb, dut.d_q, thr1);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    zeros(3);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (rr_interval !== 16'sd200 || thr1 !== 16'sd0 || {rru, qrs, searchback} !== 3'b000) begin
      errors++; $display("FAIL rst_mid rr=%0d thr1=%0d pulses=%b exp 200/0/000", rr_interval, thr1, {rru, qrs, searchback});
    end
    checks++;
    if (dut.state_q !== pt_pkg::ST_LEARN || dut.d_q !== 16'sd0 || dut.first_q !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state st=%0d d=%0d first=%b exp 0/0/1", dut.state_q, dut.d_q, dut.first_q);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_learning();
    test_first_beat();
    test_second_beat();
    test_refractory();
    test_noise();
    test_searchback();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
